// File: rtl/gfx256_bary_factor.sv
// gfx256_bary_factor
//   Barycentric factor generator sitting between the rasterizer and the
//   colour/UV/Z interpolator. For each pixel it evaluates the three edge
//   functions, divides the two pixel edge values by the triangle area with a
//   shared serial restoring divider (point_width iterations per factor), then
//   issues one write_o pulse and waits for ack_i before retiring the pixel
//   upstream with an ack_o pulse.
//
//   Factors are unsigned fractions, 1.0 == 1 << point_width. A negative edge
//   value clamps to 0 and an edge value >= area saturates to all-ones.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   write_i / ack_o               upstream request / one-cycle retire pulse
//   x_i, y_i                      pixel position (signed), stable until ack_o
//   p{0,1,2}_{x,y}_i              triangle vertices (signed), stable while busy
//   factor0_o, factor1_o          barycentric factors, held from OUT until the
//                                 next pixel capture
//   x_o, y_o                      pixel position passed downstream
//   write_o / ack_i               one-cycle write pulse / interpolator ack
//
// Optional feature
//   GFX256_BARY_SKIP_OUTSIDE_EN   when defined, pixels outside the triangle
//                                 (w0<0, w1<0 or w0+w1>area) are retired from
//                                 SETUP without a downstream write.
//
// point_width must be >= 2.

module gfx256_bary_factor #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   write_i,
  output logic                   ack_o,
  input  logic [point_width-1:0] x_i,
  input  logic [point_width-1:0] y_i,
  input  logic [point_width-1:0] p0_x_i,
  input  logic [point_width-1:0] p0_y_i,
  input  logic [point_width-1:0] p1_x_i,
  input  logic [point_width-1:0] p1_y_i,
  input  logic [point_width-1:0] p2_x_i,
  input  logic [point_width-1:0] p2_y_i,
  output logic [point_width-1:0] factor0_o,
  output logic [point_width-1:0] factor1_o,
  output logic [point_width-1:0] x_o,
  output logic [point_width-1:0] y_o,
  output logic                   write_o,
  input  logic                   ack_i
);

  localparam int W  = point_width;
  localparam int DW = W + 1;         // coordinate difference
  localparam int PW = 2 * W + 2;     // product
  localparam int EW = 2 * W + 3;     // edge function value
  localparam int CW = $clog2(W);     // iteration counter, holds 0..W-1

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DIV0,
    S_DIV1,
    S_OUT,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  // E(a,b,p) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x), full precision.
  function automatic logic signed [EW-1:0] edge_fn(
    input logic signed [W-1:0] ax, input logic signed [W-1:0] ay,
    input logic signed [W-1:0] bx, input logic signed [W-1:0] by,
    input logic signed [W-1:0] px, input logic signed [W-1:0] py
  );
    logic signed [DW-1:0] dx_ab, dy_ab, dx_ap, dy_ap;
    logic signed [PW-1:0] m0, m1;
    dx_ab = DW'(bx) - DW'(ax);
    dy_ab = DW'(by) - DW'(ay);
    dx_ap = DW'(px) - DW'(ax);
    dy_ap = DW'(py) - DW'(ay);
    m0 = PW'(dx_ab) * PW'(dy_ap);
    m1 = PW'(dy_ab) * PW'(dx_ap);
    return EW'(m0) - EW'(m1);
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EW-1:0]        rem_q, rem_d;
  logic [W-1:0]         quo_q, quo_d;
  logic                 sat_zero_q, sat_zero_d;
  logic                 sat_ones_q, sat_ones_d;
  logic [EW-1:0]        area_q, area_d;       // always positive once stored
  logic signed [EW-1:0] w0_q, w0_d;
  logic signed [EW-1:0] w1_q, w1_d;
  logic [W-1:0]         f0_q, f0_d;           // factor0 parked during DIV1
  logic [W-1:0]         x_q, x_d;
  logic [W-1:0]         y_q, y_d;
  logic [W-1:0]         factor0_q, factor0_d;
  logic [W-1:0]         factor1_q, factor1_d;
  logic                 write_q, write_d;
  logic                 ack_q, ack_d;

  // ---------------------------------------------------------------------------
  // Edge functions, evaluated in SETUP against the latched pixel
  // ---------------------------------------------------------------------------
  logic signed [EW-1:0] area_c, w0_c, w1_c;
  logic signed [EW-1:0] area_n, w0_n, w1_n;
  logic                 flip;
  logic                 outside;

  assign area_c = edge_fn(p0_x_i, p0_y_i, p1_x_i, p1_y_i, p2_x_i, p2_y_i);
  assign w0_c   = edge_fn(p1_x_i, p1_y_i, p2_x_i, p2_y_i, x_q, y_q);
  assign w1_c   = edge_fn(p2_x_i, p2_y_i, p0_x_i, p0_y_i, x_q, y_q);

  // Clockwise triangles: flip everything so area is positive and inside
  // pixels keep non-negative edge values.
  assign flip   = area_c[EW-1];
  assign area_n = flip ? -area_c : area_c;
  assign w0_n   = flip ? -w0_c   : w0_c;
  assign w1_n   = flip ? -w1_c   : w1_c;

`ifdef GFX256_BARY_SKIP_OUTSIDE_EN
  logic signed [EW:0] w_sum;
  assign w_sum   = {w0_n[EW-1], w0_n} + {w1_n[EW-1], w1_n};
  assign outside = w0_n[EW-1] | w1_n[EW-1] | (w_sum > $signed({1'b0, area_n}));
`else
  assign outside = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Serial restoring divider: quotient = floor((w << W) / area) for 0<=w<area.
  // Remainder stays below area, so one shifted compare/subtract per bit.
  // Clamp decision is taken on the first iteration and then held; iterations
  // still run so latency never depends on the data.
  // ---------------------------------------------------------------------------
  logic signed [EW-1:0] w_sel;
  logic                 first_it, last_it;
  logic                 zero_now, ones_now;
  logic [EW-1:0]        rem_in, rem_sh, rem_nx;
  logic                 q_bit;
  logic [W-1:0]         quo_nx, div_res;

  assign w_sel    = (state_q == S_DIV0) ? w0_q : w1_q;
  assign first_it = (cnt_q == '0);
  assign last_it  = (cnt_q == CW'(W - 1));
  assign zero_now = first_it ? w_sel[EW-1] : sat_zero_q;
  assign ones_now = first_it ? (!w_sel[EW-1] && (w_sel >= area_q)) : sat_ones_q;
  assign rem_in   = first_it ? ((zero_now || ones_now) ? '0 : w_sel) : rem_q;
  assign rem_sh   = EW'({rem_in, 1'b0});
  assign q_bit    = (rem_sh >= area_q);
  assign rem_nx   = q_bit ? (rem_sh - area_q) : rem_sh;
  assign quo_nx   = W'({quo_q, q_bit});
  assign div_res  = zero_now ? '0 : (ones_now ? '1 : quo_nx);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    sat_zero_d = sat_zero_q;
    sat_ones_d = sat_ones_q;
    area_d     = area_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    f0_d       = f0_q;
    x_d        = x_q;
    y_d        = y_q;
    factor0_d  = factor0_q;
    factor1_d  = factor1_q;
    write_d    = 1'b0;
    ack_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (write_i) begin
          x_d     = x_i;
          y_d     = y_i;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        area_d = area_n;
        w0_d   = w0_n;
        w1_d   = w1_n;
        cnt_d  = '0;
        if ((area_n == '0) || outside) begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DIV0;
        end
      end

      S_DIV0, S_DIV1: begin
        cnt_d      = cnt_q + CW'(1);
        rem_d      = rem_nx;
        quo_d      = quo_nx;
        sat_zero_d = zero_now;
        sat_ones_d = ones_now;
        if (last_it) begin
          cnt_d = '0;
          if (state_q == S_DIV0) begin
            f0_d    = div_res;
            state_d = S_DIV1;
          end else begin
            factor0_d = f0_q;
            factor1_d = div_res;
            write_d   = 1'b1;
            state_d   = S_OUT;
          end
        end
      end

      S_OUT: state_d = S_WAIT_ACK;

      S_WAIT_ACK: begin
        if (ack_i) begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      sat_zero_q <= 1'b0;
      sat_ones_q <= 1'b0;
      area_q     <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      f0_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      factor0_q  <= '0;
      factor1_q  <= '0;
      write_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      sat_zero_q <= sat_zero_d;
      sat_ones_q <= sat_ones_d;
      area_q     <= area_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      f0_q       <= f0_d;
      x_q        <= x_d;
      y_q        <= y_d;
      factor0_q  <= factor0_d;
      factor1_q  <= factor1_d;
      write_q    <= write_d;
      ack_q      <= ack_d;
    end
  end

  assign factor0_o = factor0_q;
  assign factor1_o = factor1_q;
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign write_o   = write_q;
  assign ack_o     = ack_q;

endmodule

// File: tb/tb_gfx256_bary_factor.sv
// Self-checking bench for gfx256_bary_factor (point_width = 16).
// Reference model computes edge functions and factors with plain 64-bit
// integer arithmetic straight from the barycentric definition.

module tb_gfx256_bary_factor;

  localparam int W = 16;
  localparam longint ONES = (longint'(1) << W) - 1;

  logic         clk_i = 1'b0;
  logic         rst_i, write_i, ack_i;
  logic         ack_o, write_o;
  logic [W-1:0] x_i, y_i, p0_x_i, p0_y_i, p1_x_i, p1_y_i, p2_x_i, p2_y_i;
  logic [W-1:0] factor0_o, factor1_o, x_o, y_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  gfx256_bary_factor #(.point_width(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .ack_o(ack_o),
    .x_i(x_i), .y_i(y_i),
    .p0_x_i(p0_x_i), .p0_y_i(p0_y_i), .p1_x_i(p1_x_i), .p1_y_i(p1_y_i),
    .p2_x_i(p2_x_i), .p2_y_i(p2_y_i),
    .factor0_o(factor0_o), .factor1_o(factor1_o), .x_o(x_o), .y_o(y_o),
    .write_o(write_o), .ack_i(ack_i)
  );

  // ---------------- reference model ----------------
  function automatic longint edge_m(longint ax, longint ay, longint bx,
                                    longint by, longint px, longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic longint fac_m(longint w, longint area);
    if (w < 0) return 0;
    if (w >= area) return ONES;
    return (w <<< W) / area;
  endfunction

  task automatic model(input longint ax, ay, bx, by, cx, cy, px, py,
                       output bit skip, output longint f0, output longint f1);
    longint area, w0, w1;
    area = edge_m(ax, ay, bx, by, cx, cy);
    w0   = edge_m(bx, by, cx, cy, px, py);
    w1   = edge_m(cx, cy, ax, ay, px, py);
    if (area < 0) begin
      area = -area; w0 = -w0; w1 = -w1;
    end
    skip = (area == 0);
`ifdef GFX256_BARY_SKIP_OUTSIDE_EN
    if (w0 < 0 || w1 < 0 || (w0 + w1) > area) skip = 1'b1;
`endif
    f0 = fac_m(w0, area);
    f1 = fac_m(w1, area);
  endtask

  // ---------------- driver ----------------
  // Cycle 0 = IDLE cycle with write_i high. Observations taken at negedges.
  task automatic run_pixel(input longint ax, ay, bx, by, cx, cy, px, py,
                           input int ack_dly,
                           output int wr_cyc, output int ack_cyc, output int nwr,
                           output logic [W-1:0] f0, output logic [W-1:0] f1,
                           output logic [W-1:0] xo, output logic [W-1:0] yo);
    @(negedge clk_i);
    p0_x_i = ax[W-1:0]; p0_y_i = ay[W-1:0];
    p1_x_i = bx[W-1:0]; p1_y_i = by[W-1:0];
    p2_x_i = cx[W-1:0]; p2_y_i = cy[W-1:0];
    x_i = px[W-1:0]; y_i = py[W-1:0];
    write_i = 1'b1;
    wr_cyc = -1; ack_cyc = -1; nwr = 0;
    f0 = 'x; f1 = 'x; xo = 'x; yo = 'x;
    for (int n = 1; n < 300 && ack_cyc < 0; n++) begin
      @(negedge clk_i);
      if (n == 1) write_i = 1'b0;
      if (write_o) begin
        nwr++;
        if (wr_cyc < 0) begin
          wr_cyc = n; f0 = factor0_o; f1 = factor1_o; xo = x_o; yo = y_o;
        end
      end
      if (ack_o) ack_cyc = n;
      ack_i = (wr_cyc >= 0) && (n == wr_cyc + ack_dly);
    end
    ack_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_i = 1'b1; write_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks += 6;
    if (ack_o !== 1'b0)    begin errors++; $display("FAIL reset_ack got %0b want 0", ack_o); end
    if (write_o !== 1'b0)  begin errors++; $display("FAIL reset_write got %0b want 0", write_o); end
    if (factor0_o !== '0)  begin errors++; $display("FAIL reset_f0 got %h want 0", factor0_o); end
    if (factor1_o !== '0)  begin errors++; $display("FAIL reset_f1 got %h want 0", factor1_o); end
    if (x_o !== '0)        begin errors++; $display("FAIL reset_x got %h want 0", x_o); end
    if (y_o !== '0)        begin errors++; $display("FAIL reset_y got %h want 0", y_o); end
    rst_i = 1'b0; write_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (write_o !== 1'b0 || ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle got wr=%0b ack=%0b want 0 0", write_o, ack_o);
    end
  endtask

  task automatic test_basic;
    int wc, ac, nw; logic [W-1:0] f0, f1, xo, yo;
    run_pixel(0, 0, 16, 0, 0, 16, 4, 4, 2, wc, ac, nw, f0, f1, xo, yo);
    checks += 8;
    if (wc !== 34)        begin errors++; $display("FAIL basic_wr_cycle got %0d want 34", wc); end
    if (nw !== 1)         begin errors++; $display("FAIL basic_wr_count got %0d want 1", nw); end
    if (f0 !== 16'h8000)  begin errors++; $display("FAIL basic_f0 got %h want 8000", f0); end
    if (f1 !== 16'h4000)  begin errors++; $display("FAIL basic_f1 got %h want 4000", f1); end
    if (xo !== 16'd4)     begin errors++; $display("FAIL basic_x got %0d want 4", xo); end
    if (yo !== 16'd4)     begin errors++; $display("FAIL basic_y got %0d want 4", yo); end
    if (ac !== 37)        begin errors++; $display("FAIL basic_ack_cycle got %0d want 37", ac); end
    if (factor0_o !== 16'h8000) begin
      errors++; $display("FAIL basic_hold got %h want 8000", factor0_o);
    end
  endtask

  task automatic test_saturate;
    int wc, ac, nw; logic [W-1:0] f0, f1, xo, yo;
    run_pixel(0, 0, 16, 0, 0, 16, 0, 0, 1, wc, ac, nw, f0, f1, xo, yo);
    checks += 4;
    if (wc !== 34)        begin errors++; $display("FAIL sat_wr_cycle got %0d want 34", wc); end
    if (f0 !== 16'hFFFF)  begin errors++; $display("FAIL sat_f0 got %h want ffff", f0); end
    if (f1 !== 16'h0000)  begin errors++; $display("FAIL sat_f1 got %h want 0000", f1); end
    if (ac !== 36)        begin errors++; $display("FAIL sat_ack_cycle got %0d want 36", ac); end
  endtask

  task automatic test_reversed;
    int wc, ac, nw; logic [W-1:0] f0, f1, xo, yo;
    run_pixel(0, 0, 0, 16, 16, 0, 4, 4, 3, wc, ac, nw, f0, f1, xo, yo);
    checks += 3;
    if (wc !== 34)        begin errors++; $display("FAIL rev_wr_cycle got %0d want 34", wc); end
    if (f0 !== 16'h8000)  begin errors++; $display("FAIL rev_f0 got %h want 8000", f0); end
    if (f1 !== 16'h4000)  begin errors++; $display("FAIL rev_f1 got %h want 4000", f1); end
  endtask

  task automatic test_degenerate;
    int wc, ac, nw; logic [W-1:0] f0, f1, xo, yo;
    run_pixel(0, 0, 8, 8, 16, 16, 3, 5, 1, wc, ac, nw, f0, f1, xo, yo);
    checks += 2;
    if (nw !== 0)  begin errors++; $display("FAIL degen_wr_count got %0d want 0", nw); end
    if (ac !== 2)  begin errors++; $display("FAIL degen_ack_cycle got %0d want 2", ac); end
  endtask

  task automatic test_outside;
    int wc, ac, nw; logic [W-1:0] f0, f1, xo, yo;
    run_pixel(0, 0, 16, 0, 0, 16, 20, 20, 1, wc, ac, nw, f0, f1, xo, yo);
`ifdef GFX256_BARY_SKIP_OUTSIDE_EN
    checks += 2;
    if (nw !== 0)  begin errors++; $display("FAIL out_wr_count got %0d want 0", nw); end
    if (ac !== 2)  begin errors++; $display("FAIL out_ack_cycle got %0d want 2", ac); end
`else
    checks += 3;
    if (nw !== 1)         begin errors++; $display("FAIL out_wr_count got %0d want 1", nw); end
    if (f0 !== 16'h0000)  begin errors++; $display("FAIL out_f0 got %h want 0000", f0); end
    if (f1 !== 16'hFFFF)  begin errors++; $display("FAIL out_f1 got %h want ffff", f1); end
`endif
  endtask

  function automatic longint rnd_c(bit full);
    logic signed [W-1:0] t;
    if (full) begin
      t = W'($urandom);
      return longint'(t);
    end
    return longint'($urandom_range(0, 95)) - 48;
  endfunction

  task automatic test_random;
    int wc, ac, nw, d; logic [W-1:0] f0, f1, xo, yo;
    longint v[8]; bit skip; longint ef0, ef1;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 8; k++) v[k] = rnd_c(it >= 45);
      d = int'($urandom_range(1, 5));
      model(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], skip, ef0, ef1);
      run_pixel(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], d,
                wc, ac, nw, f0, f1, xo, yo);
      if (skip) begin
        checks += 2;
        if (nw !== 0) begin errors++; $display("FAIL rnd%0d_skip_wr got %0d want 0", it, nw); end
        if (ac !== 2) begin errors++; $display("FAIL rnd%0d_skip_ack got %0d want 2", it, ac); end
      end else begin
        checks += 6;
        if (wc !== 34) begin errors++; $display("FAIL rnd%0d_wr_cycle got %0d want 34", it, wc); end
        if (f0 !== W'(ef0)) begin errors++; $display("FAIL rnd%0d_f0 got %h want %h", it, f0, W'(ef0)); end
        if (f1 !== W'(ef1)) begin errors++; $display("FAIL rnd%0d_f1 got %h want %h", it, f1, W'(ef1)); end
        if (xo !== W'(v[6])) begin errors++; $display("FAIL rnd%0d_x got %h want %h", it, xo, W'(v[6])); end
        if (yo !== W'(v[7])) begin errors++; $display("FAIL rnd%0d_y got %h want %h", it, yo, W'(v[7])); end
        if (ac !== 35 + d) begin errors++; $display("FAIL rnd%0d_ack got %0d want %0d", it, ac, 35 + d); end
      end
    end
  endtask

  // write_i held high; each pixel: capture n, write n+34, ack_i n+44,
  // ack_o n+45, next capture n+46. Reset lands in DIV1 of the third pixel.
  task automatic test_back_to_back;
    int wq[$]; int aq[$]; logic [W-1:0] fq[$];
    @(negedge clk_i);
    p0_x_i = 16'd0; p0_y_i = 16'd0; p1_x_i = 16'd16; p1_y_i = 16'd0;
    p2_x_i = 16'd0; p2_y_i = 16'd16; x_i = 16'd4; y_i = 16'd4;
    write_i = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk_i);
      if (write_o) begin wq.push_back(n); fq.push_back(factor0_o); end
      if (ack_o) aq.push_back(n);
      ack_i = (wq.size() > 0) && (n == wq[$] + 10);
      if (n == 116) begin
        rst_i = 1'b0;
        checks += 4;
        if (factor0_o !== '0 || factor1_o !== '0) begin
          errors++; $display("FAIL b2b_rst_factors got %h %h want 0 0", factor0_o, factor1_o);
        end
        if (x_o !== '0 || y_o !== '0) begin
          errors++; $display("FAIL b2b_rst_xy got %h %h want 0 0", x_o, y_o);
        end
        if (write_o !== 1'b0) begin errors++; $display("FAIL b2b_rst_write got %0b want 0", write_o); end
        if (ack_o !== 1'b0)   begin errors++; $display("FAIL b2b_rst_ack got %0b want 0", ack_o); end
      end
      if (n == 115) begin rst_i = 1'b1; write_i = 1'b0; ack_i = 1'b0; end
    end
    checks += 3;
    if (wq.size() !== 2 || wq[0] !== 34 || wq[1] !== 80) begin
      errors++; $display("FAIL b2b_writes got n=%0d first=%0d want 2 pulses at 34,80",
                         wq.size(), (wq.size() > 0) ? wq[0] : -1);
    end
    if (aq.size() !== 2 || aq[0] !== 45 || aq[1] !== 91) begin
      errors++; $display("FAIL b2b_acks got n=%0d first=%0d want 2 pulses at 45,91",
                         aq.size(), (aq.size() > 0) ? aq[0] : -1);
    end
    if (fq.size() < 2 || fq[0] !== 16'h8000 || fq[1] !== 16'h8000) begin
      errors++; $display("FAIL b2b_f0 got count %0d want two 8000 values", fq.size());
    end
  endtask

  initial begin
    rst_i = 1'b1; write_i = 1'b0; ack_i = 1'b0;
    x_i = '0; y_i = '0;
    p0_x_i = '0; p0_y_i = '0; p1_x_i = '0; p1_y_i = '0; p2_x_i = '0; p2_y_i = '0;
    test_reset;
    test_basic;
    test_saturate;
    test_reversed;
    test_degenerate;
    test_outside;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
